// File: rtl/lc3_br_pkg.sv
// lc3_br_pkg: shared types and constants for the LC-3 branch sequencer.
//   br_state_t  - sequencer FSM states
//   OP_BR       - BR opcode value
//   PCMUX_*     - PC source selects
//   ADDR2_*     - ADDR2MUX selects
//   NZP_RESET   - condition codes after reset (Z set)
//   cc_gen()    - N/Z/P encoding of a bus value
package lc3_br_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        CALC_BEN,
        BR_TAKE,
        DONE
    } br_state_t;

    localparam logic [3:0] OP_BR       = 4'b0000;
    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;
    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [2:0] NZP_RESET   = 3'b010;

    function automatic logic [2:0] cc_gen(input logic [15:0] v);
        return (v == 16'd0) ? 3'b010 : v[15] ? 3'b100 : 3'b001;
    endfunction

endpackage

// File: rtl/cc_reg.sv
// cc_reg: N/Z/P condition-code register loaded from the datapath bus.
//   Clk   - system clock
//   Reset - synchronous active-high reset (nzp -> Z)
//   LD_CC - load condition codes from Bus this cycle
//   Bus   - datapath bus value
//   nzp   - registered condition codes {N,Z,P}
module cc_reg
    import lc3_br_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        LD_CC,
    input  logic [15:0] Bus,
    output logic [2:0]  nzp
);

    always_ff @(posedge Clk) begin
        if (Reset)
            nzp <= NZP_RESET;
        else if (LD_CC)
            nzp <= cc_gen(Bus);
    end

endmodule

// File: rtl/br_sequencer.sv
// br_sequencer: LC-3 BR instruction sequencer (decode, BEN evaluation, PC load).
//   Clk, Reset      - clock and synchronous active-high reset
//   start           - evaluate IR (accepted only while idle)
//   IR              - instruction word {opcode, nzp mask, PCoffset9}
//   Bus, LD_CC      - condition-code source and load strobe
//   busy, done      - sequence in progress / one-cycle completion pulse
//   taken, BEN      - last sequence result / registered branch enable
//   nzp             - current condition codes
//   LD_PC, PCMUX, ADDR2MUX, ADDR1MUX - PC update controls to the datapath
//   br_count        - saturating count of taken branches
module br_sequencer
    import lc3_br_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] IR,
    input  logic [15:0] Bus,
    input  logic        LD_CC,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic        BEN,
    output logic [2:0]  nzp,
    output logic        LD_PC,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic        ADDR1MUX,
    output logic [7:0]  br_count
);

    br_state_t  state, state_n;
    logic [3:0] op_q;
    logic [2:0] mask_q;
    logic       ben_n;
    logic       unused_ir;

    // The offset itself goes to the datapath adder; only its select lives here.
    assign unused_ir = ^IR[8:0];

    cc_reg u_cc (
        .Clk   (Clk),
        .Reset (Reset),
        .LD_CC (LD_CC),
        .Bus   (Bus),
        .nzp   (nzp)
    );

    // Uses the registered nzp, so a same-cycle LD_CC does not affect BEN.
    assign ben_n = |(mask_q & nzp);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            op_q     <= 4'd0;
            mask_q   <= 3'd0;
            BEN      <= 1'b0;
            taken    <= 1'b0;
            br_count <= 8'd0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                op_q   <= IR[15:12];
                mask_q <= IR[11:9];
            end
            if (state == DECODE && op_q != OP_BR)
                taken <= 1'b0;
            if (state == CALC_BEN) begin
                BEN <= ben_n;
                if (!ben_n)
                    taken <= 1'b0;
            end
            if (state == BR_TAKE) begin
                taken    <= 1'b1;
                br_count <= br_count + {7'd0, br_count != 8'hFF};
            end
        end
    end

    always_comb begin
        state_n  = state;
        busy     = state != IDLE;
        done     = state == DONE;
        LD_PC    = state == BR_TAKE;
        PCMUX    = LD_PC ? PCMUX_ADDER : PCMUX_PC1;
        ADDR2MUX = LD_PC ? ADDR2_OFF9 : ADDR2_ZERO;
        ADDR1MUX = 1'b0;
        case (state)
            IDLE:     state_n = start ? DECODE : IDLE;
            DECODE:   state_n = (op_q == OP_BR) ? CALC_BEN : DONE;
            CALC_BEN: state_n = ben_n ? BR_TAKE : DONE;
            BR_TAKE:  state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

endmodule

// File: doc/br_sequencer.md
BR_SEQUENCER -- requirements
Module: br_sequencer

Interface
REQ-001: Clk  input  1  system clock; all state updates on rising edge.
REQ-002: Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-003: start  input  1  request to evaluate the instruction on IR; sampled only in IDLE.
REQ-004: IR  input  16  instruction word; IR[15:12] opcode, IR[11:9] nzp mask, IR[8:0] PCoffset9.
REQ-005: Bus  input  16  datapath bus value used for condition-code generation.
REQ-006: LD_CC  input  1  load N/Z/P from Bus this cycle.
REQ-007: busy  output  1  high in every state except IDLE.
REQ-008: done  output  1  one-cycle pulse when a sequence completes.
REQ-009: taken  output  1  registered result of the last completed sequence; 1 = branch taken.
REQ-010: BEN  output  1  registered branch-enable bit.
REQ-011: nzp  output  3  current condition codes {N,Z,P}.
REQ-012: LD_PC  output  1  PC load strobe to datapath.
REQ-013: PCMUX  output  2  PC source select; 2'b10 = address adder, else 2'b00 (PC+1).
REQ-014: ADDR2MUX  output  2  2'b10 = SEXT(IR[8:0]) while LD_PC high, else 2'b00.
REQ-015: ADDR1MUX  output  1  0 = PC; constant 0 in this block.
REQ-016: br_count  output  8  number of taken branches since reset, saturating.

Function
REQ-017: Condition codes SHALL update on any cycle with LD_CC=1, in every state: Bus==0 -> 3'b010; Bus[15]=1 -> 3'b100; else 3'b001.
REQ-018: With LD_CC=0, nzp SHALL hold its value.
REQ-019: FSM states SHALL be IDLE, DECODE, CALC_BEN, BR_TAKE, DONE.
REQ-020: IDLE -> DECODE when start=1; IR SHALL be latched into an internal register on that edge; otherwise remain in IDLE.
REQ-021: DECODE -> CALC_BEN if latched opcode == 4'b0000; otherwise -> DONE with taken set to 0.
REQ-022: In CALC_BEN, BEN SHALL load |(IR_latched[11:9] & nzp) using the registered nzp, i.e. the value before any same-cycle LD_CC update.
REQ-023: CALC_BEN -> BR_TAKE when the newly computed BEN is 1; otherwise -> DONE with taken=0.
REQ-024: BR_TAKE SHALL last exactly one cycle with LD_PC=1, PCMUX=2'b10, ADDR2MUX=2'b10, ADDR1MUX=0.
REQ-025: On the BR_TAKE edge, taken SHALL be set to 1 and br_count SHALL increment, saturating at 8'hFF; then -> DONE.
REQ-026: DONE SHALL assert done for one cycle, then -> IDLE.
REQ-027: Latency from start to done: 3 cycles for a non-branch, 4 cycles for a branch not taken, 5 cycles for a branch taken.
REQ-028: start while busy SHALL be ignored and not queued.
REQ-029: A change on IR after the start cycle SHALL NOT affect the sequence in progress.
REQ-030: A BR with nzp mask 3'b000 SHALL never be taken; mask 3'b111 SHALL always be taken.

Reset
REQ-031: Reset=1 SHALL force state IDLE, nzp=3'b010, BEN=0, taken=0, br_count=0, done=0, LD_PC=0, PCMUX=0, ADDR2MUX=0.
REQ-032: Reset SHALL take priority over LD_CC and start in the same cycle.
REQ-033: Reset mid-sequence SHALL abort the sequence with no LD_PC pulse and no done pulse.

Structure
REQ-034: Package lc3_br_pkg SHALL hold the FSM state enum, the BR opcode constant 4'b0000, the PCMUX/ADDR2MUX select constants and the nzp reset value 3'b010.
REQ-035: The N/Z/P generation and register SHALL be one sub-module, cc_reg (inputs Clk, Reset, LD_CC, Bus; output nzp).
REQ-036: All outputs SHALL be registered or decoded from the state register only, with no combinational path from start or IR.

Verification
REQ-037: Reset, then observe -> nzp=010, BEN=0, busy=0, br_count=0.
REQ-038: LD_CC with Bus=16'h8000, then start with IR=16'h0805 (BRn) -> LD_PC pulse with PCMUX=10 at cycle 4, done at cycle 5, taken=1, br_count=1.
REQ-039: LD_CC with Bus=16'h0000, then start with IR=16'h0205 (BRp) -> no LD_PC, done at cycle 4, taken=0.
REQ-040: Start with IR=16'h1021 (ADD) -> done at cycle 3, BEN unchanged, no LD_PC.
REQ-041: nzp=001, start BRp, with LD_CC and Bus=16'hFFFF in the CALC_BEN cycle -> BEN=1, branch taken, nzp=100 afterwards; a second start pulse during busy is ignored.
REQ-042: 256 taken branches -> br_count=8'hFF; Reset asserted in BR_TAKE-1 -> no LD_PC, no done, state IDLE.
